// File: rtl/kernel_loader.sv
// kernel_loader: fetches KERNEL_SIZE weight bytes from a synchronous weight memory
// starting at a captured base address and streams them to the kernel bank as
// one-byte writes (new_kernel / kernel_write_enable).
// Optional feature: define KERNEL_LOADER_CHECKSUM_EN to build the 16-bit running
// byte sum on checksum; otherwise checksum is tied to zero.
module kernel_loader #(
   parameter int unsigned KERNEL_SIZE = 49,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned RD_LATENCY  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  hold,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [7:0]            mem_rdata,
   output logic [7:0]            new_kernel,
   output logic                  kernel_write_enable,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           checksum
);

   localparam logic [5:0] LastIssue = 6'(KERNEL_SIZE - 1);
   localparam logic [5:0] KSize     = 6'(KERNEL_SIZE);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_t;

   state_t                state_q, state_d;
   logic [5:0]            issue_cnt_q;
   logic [5:0]            wr_cnt_q;
   logic [RD_LATENCY-1:0] vpipe_q;
   logic                  issue;
   logic                  accept;
   logic                  tail;

   assign issue     = (state_q == StFetch) && !hold;
   assign accept    = (state_q == StIdle) && start;
   // Oldest issue strobe: its read data is on mem_rdata this cycle.
   assign tail      = vpipe_q[RD_LATENCY-1];
   assign mem_rd_en = issue;
   assign busy      = (state_q == StFetch) || (state_q == StDrain);
   assign done      = (state_q == StDone);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StFetch;
         StFetch: if (issue && (issue_cnt_q == LastIssue)) state_d = StDrain;
         StDrain: if (wr_cnt_q == KSize) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Read issue: address and issue count advance only on cycles that issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr    <= '0;
         issue_cnt_q <= '0;
      end else if (accept) begin
         mem_addr    <= base_addr;
         issue_cnt_q <= '0;
      end else if (issue) begin
         mem_addr    <= mem_addr + ADDR_WIDTH'(1);
         issue_cnt_q <= issue_cnt_q + 6'd1;
      end
   end

   // Valid pipeline tracking in-flight reads; hold never stalls it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe_q <= '0;
      end else begin
         vpipe_q <= RD_LATENCY'({vpipe_q, issue});
      end
   end

   // Write side: register returning data toward the kernel bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         new_kernel          <= '0;
         kernel_write_enable <= 1'b0;
         wr_cnt_q            <= '0;
      end else begin
         kernel_write_enable <= tail;
         if (tail) begin
            new_kernel <= mem_rdata;
         end
         if (accept) begin
            wr_cnt_q <= '0;
         end else if (tail) begin
            wr_cnt_q <= wr_cnt_q + 6'd1;
         end
      end
   end

`ifdef KERNEL_LOADER_CHECKSUM_EN
   logic [15:0] checksum_q;

   // Running sum, updated together with the byte it covers becoming visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum_q <= '0;
      end else if (accept) begin
         checksum_q <= '0;
      end else if (tail) begin
         checksum_q <= checksum_q + {8'h00, mem_rdata};
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_kernel_loader.sv
// tb_kernel_loader: drives two kernel_loader instances (RD_LATENCY 1 and 4) with the
// same stimulus, models the weight memory, and compares observed issue/write/done
// timelines against a cycle-level reference computed from the load rules.
module tb_kernel_loader;

   localparam int K    = 49;
   localparam int NCYC = 120;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic        hold = 1'b0;

   logic        rd_w   [2];
   logic [15:0] addr_w [2];
   logic [7:0]  rdata_w[2];
   logic [7:0]  nk_w   [2];
   logic        we_w   [2];
   logic        busy_w [2];
   logic        done_w [2];
   logic [15:0] cs_w   [2];

   logic [7:0]  mem [0:65535];
   logic [7:0]  p1;
   logic [7:0]  p4 [0:3];

   bit          hold_pat [0:127];
   int          exp_we[2][0:127], obs_we[2][0:127];
   int          n_exp_we[2], n_obs_we[2];
   int          exp_rd[2][0:127], obs_rd[2][0:127];
   int          n_exp_rd[2], n_obs_rd[2];
   int          exp_done[2], obs_done[2], n_obs_done[2];
   int          exp_busy[2], obs_busy[2];
   logic [15:0] exp_cs[2], obs_cs[2], obs_cs_done[2];
   bit          obs_rst_zero[2];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   kernel_loader #(.KERNEL_SIZE(K), .ADDR_WIDTH(16), .RD_LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .hold(hold),
      .mem_rd_en(rd_w[0]), .mem_addr(addr_w[0]), .mem_rdata(rdata_w[0]),
      .new_kernel(nk_w[0]), .kernel_write_enable(we_w[0]), .busy(busy_w[0]),
      .done(done_w[0]), .checksum(cs_w[0])
   );

   kernel_loader #(.KERNEL_SIZE(K), .ADDR_WIDTH(16), .RD_LATENCY(4)) u_l4 (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .hold(hold),
      .mem_rd_en(rd_w[1]), .mem_addr(addr_w[1]), .mem_rdata(rdata_w[1]),
      .new_kernel(nk_w[1]), .kernel_write_enable(we_w[1]), .busy(busy_w[1]),
      .done(done_w[1]), .checksum(cs_w[1])
   );

   // Synchronous weight memory with 1- and 4-cycle read latency.
   always @(posedge clk) begin
      p1    <= mem[addr_w[0]];
      p4[0] <= mem[addr_w[1]];
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
   end
   assign rdata_w[0] = p1;
   assign rdata_w[1] = p4[3];

   task automatic clear_hold();
      for (int i = 0; i < 128; i++) hold_pat[i] = 1'b0;
   endtask

   // Reference: issues happen on non-hold cycles from cycle 1 at base+n; byte n is
   // written L+1 cycles after its issue; done follows the last write by one cycle.
   task automatic model_load(input logic [15:0] base, input int rst_at);
      for (int d = 0; d < 2; d++) begin
         int          lat, issued, c, last, wc, sum;
         logic [15:0] a;
         lat = (d == 0) ? 1 : 4;
         issued = 0; c = 1; last = 0; sum = 0;
         n_exp_we[d] = 0; n_exp_rd[d] = 0;
         while (issued < K && (rst_at < 0 || c < rst_at)) begin
            if (!hold_pat[c]) begin
               a = base + 16'(issued);
               exp_rd[d][n_exp_rd[d]] = c * 65536 + int'(a);
               n_exp_rd[d]++;
               wc = c + lat + 1;
               if (rst_at < 0 || wc < rst_at) begin
                  exp_we[d][n_exp_we[d]] = wc * 256 + int'(mem[a]);
                  n_exp_we[d]++;
                  sum += int'(mem[a]);
               end
               issued++;
               last = c;
            end
            c++;
         end
         if (rst_at < 0) begin
            exp_done[d] = last + lat + 2;
            exp_busy[d] = last + lat + 1;
         end else begin
            exp_done[d] = -1;
            exp_busy[d] = rst_at - 1;
         end
`ifdef KERNEL_LOADER_CHECKSUM_EN
         exp_cs[d] = (rst_at < 0) ? 16'(sum) : 16'h0000;
`else
         exp_cs[d] = 16'h0000;
`endif
      end
   endtask

   // Drives one load window (cycle 0 = start cycle) and records what both DUTs do.
   task automatic run_load(input logic [15:0] base, input int start_until, input int rst_at);
      for (int d = 0; d < 2; d++) begin
         n_obs_we[d] = 0; n_obs_rd[d] = 0; obs_done[d] = -1; n_obs_done[d] = 0;
         obs_busy[d] = 0; obs_cs_done[d] = '0; obs_rst_zero[d] = 1'b0;
      end
      base_addr = base;
      for (int c = 0; c < NCYC; c++) begin
         start = (c <= start_until);
         hold  = hold_pat[c];
         rst   = (rst_at >= 0 && c == rst_at);
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (we_w[d]) begin
               obs_we[d][n_obs_we[d]] = c * 256 + int'(nk_w[d]);
               n_obs_we[d]++;
            end
            if (rd_w[d]) begin
               obs_rd[d][n_obs_rd[d]] = c * 65536 + int'(addr_w[d]);
               n_obs_rd[d]++;
            end
            if (done_w[d]) begin
               if (n_obs_done[d] == 0) begin
                  obs_done[d]    = c;
                  obs_cs_done[d] = cs_w[d];
               end
               n_obs_done[d]++;
            end
            if (busy_w[d]) obs_busy[d]++;
            if (c == rst_at)
               obs_rst_zero[d] = ({addr_w[d], nk_w[d], we_w[d], busy_w[d], done_w[d],
                                   cs_w[d], rd_w[d]} === '0);
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0; hold = 1'b0; rst = 1'b0;
      for (int d = 0; d < 2; d++) obs_cs[d] = cs_w[d];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if ({addr_w[d], nk_w[d], we_w[d], busy_w[d], done_w[d], cs_w[d], rd_w[d]} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs[L%0d] got addr=%h nk=%h we=%b busy=%b done=%b cs=%h rd=%b required all 0",
                     d, addr_w[d], nk_w[d], we_w[d], busy_w[d], done_w[d], cs_w[d], rd_w[d]);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      for (int k = 0; k < K; k++) mem[16'h0100 + 16'(k)] = 8'(k + 1);
      clear_hold();
      model_load(16'h0100, -1);
      run_load(16'h0100, 0, -1);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (n_obs_we[d] !== K) begin
            miscompares++;
            $display("FAIL basic_nwrites[L%0d] got %0d required %0d", d, n_obs_we[d], K);
         end
         for (int i = 0; i < n_exp_we[d] && i < n_obs_we[d]; i++) begin
            vectors++;
            if (obs_we[d][i] !== exp_we[d][i]) begin
               miscompares++;
               $display("FAIL basic_write[L%0d][%0d] got cyc %0d byte %0d required cyc %0d byte %0d",
                        d, i, obs_we[d][i] / 256, obs_we[d][i] % 256,
                        exp_we[d][i] / 256, exp_we[d][i] % 256);
            end
         end
         vectors++;
         if (n_obs_we[d] > 0 && obs_we[d][0] !== ((d == 0 ? 3 : 6) * 256 + 1)) begin
            miscompares++;
            $display("FAIL basic_first_write[L%0d] got cyc %0d byte %0d required cyc %0d byte 1",
                     d, obs_we[d][0] / 256, obs_we[d][0] % 256, d == 0 ? 3 : 6);
         end
         vectors++;
         if (obs_done[d] !== (d == 0 ? 52 : 55) || n_obs_done[d] !== 1) begin
            miscompares++;
            $display("FAIL basic_done[L%0d] got cyc %0d x%0d required cyc %0d x1",
                     d, obs_done[d], n_obs_done[d], d == 0 ? 52 : 55);
         end
         vectors++;
         if (obs_busy[d] !== exp_busy[d]) begin
            miscompares++;
            $display("FAIL basic_busy[L%0d] got %0d cycles required %0d", d, obs_busy[d], exp_busy[d]);
         end
`ifdef KERNEL_LOADER_CHECKSUM_EN
         vectors++;
         if (obs_cs_done[d] !== 16'd1225 || obs_cs[d] !== 16'd1225) begin
            miscompares++;
            $display("FAIL basic_checksum[L%0d] got done=%0d end=%0d required 1225",
                     d, obs_cs_done[d], obs_cs[d]);
         end
`else
         vectors++;
         if (obs_cs_done[d] !== 16'd0 || obs_cs[d] !== 16'd0) begin
            miscompares++;
            $display("FAIL basic_checksum[L%0d] got done=%0d end=%0d required 0",
                     d, obs_cs_done[d], obs_cs[d]);
         end
`endif
      end
   endtask

   task automatic test_hold_and_wrap(input string name, input logic [15:0] base,
                                     input int hs, input int he);
      clear_hold();
      for (int c = hs; c <= he; c++) hold_pat[c] = 1'b1;
      model_load(base, -1);
      run_load(base, 0, -1);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (n_obs_rd[d] !== n_exp_rd[d] || n_obs_we[d] !== n_exp_we[d]) begin
            miscompares++;
            $display("FAIL %s_counts[L%0d] got rd=%0d wr=%0d required rd=%0d wr=%0d",
                     name, d, n_obs_rd[d], n_obs_we[d], n_exp_rd[d], n_exp_we[d]);
         end
         for (int i = 0; i < n_exp_rd[d] && i < n_obs_rd[d]; i++) begin
            vectors++;
            if (obs_rd[d][i] !== exp_rd[d][i]) begin
               miscompares++;
               $display("FAIL %s_issue[L%0d][%0d] got cyc %0d addr %h required cyc %0d addr %h",
                        name, d, i, obs_rd[d][i] / 65536, obs_rd[d][i] % 65536,
                        exp_rd[d][i] / 65536, exp_rd[d][i] % 65536);
            end
         end
         for (int i = 0; i < n_exp_we[d] && i < n_obs_we[d]; i++) begin
            vectors++;
            if (obs_we[d][i] !== exp_we[d][i]) begin
               miscompares++;
               $display("FAIL %s_write[L%0d][%0d] got cyc %0d byte %0d required cyc %0d byte %0d",
                        name, d, i, obs_we[d][i] / 256, obs_we[d][i] % 256,
                        exp_we[d][i] / 256, exp_we[d][i] % 256);
            end
         end
         vectors++;
         if (obs_done[d] !== exp_done[d] || n_obs_done[d] !== 1 || obs_cs[d] !== exp_cs[d]) begin
            miscompares++;
            $display("FAIL %s_done[L%0d] got cyc %0d x%0d cs %h required cyc %0d x1 cs %h",
                     name, d, obs_done[d], n_obs_done[d], obs_cs[d], exp_done[d], exp_cs[d]);
         end
      end
   endtask

   task automatic test_start_ignored();
      clear_hold();
      model_load(16'h2000, -1);
      run_load(16'h2000, K + 3, -1);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (n_obs_we[d] !== K || n_obs_done[d] !== 1 || obs_done[d] !== exp_done[d]) begin
            miscompares++;
            $display("FAIL start_ignored[L%0d] got wr=%0d done x%0d at %0d required wr=%0d x1 at %0d",
                     d, n_obs_we[d], n_obs_done[d], obs_done[d], K, exp_done[d]);
         end
      end
      model_load(16'h3000, -1);
      run_load(16'h3000, 0, -1);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (n_obs_we[d] !== K || obs_done[d] !== exp_done[d] ||
             (n_obs_we[d] > 0 && obs_we[d][K-1] !== exp_we[d][K-1])) begin
            miscompares++;
            $display("FAIL restart_after_idle[L%0d] got wr=%0d done=%0d required wr=%0d done=%0d",
                     d, n_obs_we[d], obs_done[d], K, exp_done[d]);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_hold();
      model_load(16'h4000, 20);
      run_load(16'h4000, 0, 20);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (!obs_rst_zero[d]) begin
            miscompares++;
            $display("FAIL reset_mid_zero[L%0d] got nonzero outputs required all 0", d);
         end
         vectors++;
         if (n_obs_we[d] !== n_exp_we[d] || n_obs_done[d] !== 0 || obs_cs[d] !== exp_cs[d] ||
             obs_busy[d] !== exp_busy[d]) begin
            miscompares++;
            $display("FAIL reset_mid_aftermath[L%0d] got wr=%0d done=%0d cs=%h busy=%0d required wr=%0d done=0 cs=%h busy=%0d",
                     d, n_obs_we[d], n_obs_done[d], obs_cs[d], obs_busy[d],
                     n_exp_we[d], exp_cs[d], exp_busy[d]);
         end
      end
      model_load(16'h5000, -1);
      run_load(16'h5000, 0, -1);
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < n_exp_we[d] && i < n_obs_we[d]; i++) begin
            vectors++;
            if (obs_we[d][i] !== exp_we[d][i]) begin
               miscompares++;
               $display("FAIL reset_reload_write[L%0d][%0d] got cyc %0d byte %0d required cyc %0d byte %0d",
                        d, i, obs_we[d][i] / 256, obs_we[d][i] % 256,
                        exp_we[d][i] / 256, exp_we[d][i] % 256);
            end
         end
         vectors++;
         if (n_obs_we[d] !== K || obs_done[d] !== exp_done[d] || obs_cs[d] !== exp_cs[d]) begin
            miscompares++;
            $display("FAIL reset_reload[L%0d] got wr=%0d done=%0d cs=%h required wr=%0d done=%0d cs=%h",
                     d, n_obs_we[d], obs_done[d], obs_cs[d], K, exp_done[d], exp_cs[d]);
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 4; t++) begin
         logic [15:0] base;
         base = 16'($urandom);
         clear_hold();
         for (int c = 0; c <= 30; c++) hold_pat[c] = ($urandom_range(0, 3) == 0);
         model_load(base, -1);
         run_load(base, 0, -1);
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (n_obs_we[d] !== n_exp_we[d] || n_obs_rd[d] !== n_exp_rd[d]) begin
               miscompares++;
               $display("FAIL random%0d_counts[L%0d] got rd=%0d wr=%0d required rd=%0d wr=%0d",
                        t, d, n_obs_rd[d], n_obs_we[d], n_exp_rd[d], n_exp_we[d]);
            end
            for (int i = 0; i < n_exp_we[d] && i < n_obs_we[d]; i++) begin
               vectors++;
               if (obs_we[d][i] !== exp_we[d][i] || obs_rd[d][i] !== exp_rd[d][i]) begin
                  miscompares++;
                  $display("FAIL random%0d_xfer[L%0d][%0d] got rd %0d/%h wr %0d/%0d required rd %0d/%h wr %0d/%0d",
                           t, d, i, obs_rd[d][i] / 65536, obs_rd[d][i] % 65536,
                           obs_we[d][i] / 256, obs_we[d][i] % 256,
                           exp_rd[d][i] / 65536, exp_rd[d][i] % 65536,
                           exp_we[d][i] / 256, exp_we[d][i] % 256);
               end
            end
            vectors++;
            if (obs_done[d] !== exp_done[d] || obs_busy[d] !== exp_busy[d] ||
                obs_cs_done[d] !== exp_cs[d] || obs_cs[d] !== exp_cs[d]) begin
               miscompares++;
               $display("FAIL random%0d_done[L%0d] got done=%0d busy=%0d cs=%h/%h required done=%0d busy=%0d cs=%h",
                        t, d, obs_done[d], obs_busy[d], obs_cs_done[d], obs_cs[d],
                        exp_done[d], exp_busy[d], exp_cs[d]);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      clear_hold();
      #1;
      test_reset();
      test_basic();
      test_hold_and_wrap("hold", 16'h0200, 10, 14);
      test_hold_and_wrap("wrap", 16'hFFF0, -1, -2);
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/kernel_loader.md
# kernel_loader

Transmit-side companion of the kernel bank: on a start request it fetches KERNEL_SIZE weight bytes from a synchronous weight memory, starting at a base address, and streams them as one-byte writes on the bank's new_kernel / kernel_write_enable interface. It sits between the weight SRAM and the kernel bank, so the multiplier array sees a fully loaded kernel once done pulses.

## Interface
- KERNEL_SIZE, 49, bytes transferred per load (1..63)
- ADDR_WIDTH, 16, weight memory address width
- RD_LATENCY, 1, cycles from mem_rd_en to valid mem_rdata (1..4)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  load request; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first weight address; captured with start
- hold  in  1  pauses read issue while high
- mem_rd_en  out  1  read strobe to weight memory; combinational: high in FETCH when hold=0
- mem_addr  out  ADDR_WIDTH  registered read address
- mem_rdata  in  8  read data, valid RD_LATENCY cycles after mem_rd_en
- new_kernel  out  8  registered byte to kernel bank
- kernel_write_enable  out  1  registered, one cycle per byte
- busy  out  1  high in FETCH and DRAIN
- done  out  1  one-cycle pulse after the last byte write
- checksum  out  16  running byte sum (see Configuration)

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 captures base_addr into mem_addr, clears issue and write counters (6 bits each), clears checksum, goes to FETCH. start=0: stay.
- FETCH: each cycle with hold=0 issues one read at mem_addr, then mem_addr+1 and issue count+1. When issue count reaches KERNEL_SIZE-1 with an issue, go to DRAIN. hold=1: no issue; address and count frozen.
- Valid pipeline: RD_LATENCY-deep shift register of issue strobes. When its tail is 1, mem_rdata is registered into new_kernel, kernel_write_enable=1 next cycle, and write count increments.
- In-flight reads always complete; hold never drops or delays returning data.
- DRAIN: wait until write count reaches KERNEL_SIZE, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- mem_addr increments modulo 2^ADDR_WIDTH (wraps from max to 0 silently).
- start outside IDLE (including DONE) is ignored; no queuing.
- Exactly KERNEL_SIZE writes per load; the bank must be at write pointer 0 (freshly reset) beforehand.

## Timing
- Reset (async, any state): state IDLE; mem_addr=0, new_kernel=0, kernel_write_enable=0, busy=0, done=0, checksum=0, counters and pipeline cleared. mem_rd_en=0 as a consequence. In-flight reads are discarded.
- Cycle 0: start sampled at the closing edge. Cycles 1..KERNEL_SIZE (hold=0): mem_rd_en=1, addresses base..base+KERNEL_SIZE-1.
- Byte k issued in cycle c: kernel_write_enable=1 with that byte in cycle c+RD_LATENCY+1.
- No hold, L=RD_LATENCY: writes in cycles L+2..KERNEL_SIZE+L+1; done in cycle KERNEL_SIZE+L+2; busy high cycles 1..KERNEL_SIZE+L+1 and low during done.
- Each hold cycle during FETCH delays every later issue, write and done by one cycle.
- hold in IDLE, DRAIN or DONE: no effect.

## Configuration
- KERNEL_LOADER_CHECKSUM_EN defined: checksum is a 16-bit wrapping sum of every byte written in the current load. It updates in the same cycle as kernel_write_enable, is cleared on start acceptance, and holds its value after done until the next start.
- Not defined: checksum is tied to 0 and the adder is not built.

## Test plan
- Basic load: rst pulse, RD_LATENCY=1, memory[0x100+k]=k+1, start with base_addr=0x100 -> 49 writes of 1..49 in cycles 3..51, done cycle 52, bank kernel_reg_48=49, checksum=1225 (macro on) or 0 (macro off).
- Hold: hold=1 for cycles 10..14 during FETCH -> no mem_rd_en those cycles, no dropped or duplicated bytes, done 5 cycles later (cycle 57).
- Latency sweep: RD_LATENCY=4 -> first write cycle 6, done cycle 55, byte order intact.
- Address wrap: ADDR_WIDTH=16, base_addr=0xFFF0 -> addresses 0xFFF0..0xFFFF then 0x0000..0x0020, 49 writes.
- Start ignored: start pulses held high through busy and in the done cycle -> exactly one load of 49 writes, return to IDLE; a second start after IDLE begins a new load.
- Reset mid-load: rst asserted in cycle 20 -> all outputs 0 immediately, no further writes, next start performs a full clean 49-byte load.
